// File: rtl/tx_framer.sv
// Store-and-forward transmit framer: buffers a whole frame, then streams it to the MAC
// with a valid/ready handshake, padding short frames out to MIN_FRM beats.
module tx_framer #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter int unsigned       LEN_W    = 16,
    parameter int unsigned       MIN_FRM  = 64,
    parameter logic [DATA_W-1:0] PAD_BYTE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_data_valid,
    input  logic [LEN_W-1:0]  frm_len,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              valid_flag,
    input  logic              tx_mac_ready,
    output logic              last_byte,
    output logic              frm_err
);

    localparam int unsigned      AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_FRM);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StPad} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              frm_err_q, frm_err_d;
    logic              wr_en;
    logic [LEN_W-1:0]  wr_nxt;
    logic              data_last;
    logic              pad_last;
    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_nxt    = wr_cnt_q + 1'b1;
    assign data_last = (rd_cnt_q == len_q - 1'b1);
    assign pad_last  = (rd_cnt_q == MinLen - 1'b1);
    assign frm_err   = frm_err_q;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        len_d      = len_q;
        frm_err_d  = 1'b0;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        valid_flag = 1'b0;
        tx_data_o  = '0;
        last_byte  = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (tx_data_valid) begin
                    if (frm_len == '0 || frm_len > MaxLen) begin
                        frm_err_d = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        len_d    = frm_len;
                        wr_cnt_d = LEN_W'(1);
                        state_d  = (frm_len == LEN_W'(1)) ? StSend : StLoad;
                    end
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (tx_data_valid) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_nxt;
                    if (wr_nxt == len_q) state_d = StSend;
                end
            end
            StSend: begin
                valid_flag = 1'b1;
                tx_data_o  = mem[rd_cnt_q[AW-1:0]];
                last_byte  = data_last && (len_q >= MinLen);
                if (tx_mac_ready) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (data_last) begin
                        if (len_q >= MinLen) begin
                            state_d  = StIdle;
                            rd_cnt_d = '0;
                            wr_cnt_d = '0;
                        end else begin
                            state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                // rd_cnt keeps counting total beats so the pad stops at MIN_FRM
                valid_flag = 1'b1;
                tx_data_o  = PAD_BYTE;
                last_byte  = pad_last;
                if (tx_mac_ready) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (pad_last) begin
                        state_d  = StIdle;
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            len_q     <= '0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            len_q     <= len_d;
            frm_err_q <= frm_err_d;
        end
    end

    // Buffer is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt_q[AW-1:0]] <= tx_data;
    end

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: table-driven frames with a beat scoreboard,
// plus hand sequences for reject, mid-frame reset and a narrow 16-bit variant.
module tb_tx_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  tx_data = '0;
    logic        tx_data_valid = 1'b0;
    logic [15:0] frm_len = '0;
    logic        in_ready;
    logic [7:0]  tx_data_o;
    logic        valid_flag;
    logic        tx_mac_ready = 1'b1;
    logic        last_byte;
    logic        frm_err;

    logic [15:0] d_w = '0;
    logic        v_w = 1'b0;
    logic [7:0]  len_w = '0;
    logic        ir_w;
    logic [15:0] do_w;
    logic        vf_w;
    logic        rdy_w = 1'b1;
    logic        lb_w;
    logic        fe_w;

    tx_framer dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .frm_len(frm_len), .in_ready(in_ready), .tx_data_o(tx_data_o),
        .valid_flag(valid_flag), .tx_mac_ready(tx_mac_ready), .last_byte(last_byte),
        .frm_err(frm_err)
    );

    tx_framer #(
        .DATA_W(16), .DEPTH(16), .LEN_W(8), .MIN_FRM(4), .PAD_BYTE(16'hA5A5)
    ) dut_w (
        .clk(clk), .rst(rst), .tx_data(d_w), .tx_data_valid(v_w),
        .frm_len(len_w), .in_ready(ir_w), .tx_data_o(do_w),
        .valid_flag(vf_w), .tx_mac_ready(rdy_w), .last_byte(lb_w),
        .frm_err(fe_w)
    );

    typedef struct {
        int         len;
        logic [7:0] base;
        int         rdy;
        int         exp_beats;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q[$];
    beat_t mb;
    vec_t  vecs[6];
    int    errors = 0;
    int    checks = 0;
    int    beats_seen = 0;
    int    rdy_mode = 0;
    int    rcnt = 0;
    bit    hold = 1'b0;
    logic [7:0] h_data;
    logic       h_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready pattern: steady high, or toggled every rdy_mode cycles
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            tx_mac_ready = 1'b1;
            rcnt = 0;
        end else begin
            rcnt++;
            if (rcnt >= rdy_mode) begin
                rcnt = 0;
                tx_mac_ready = ~tx_mac_ready;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", valid_flag, 1);
                chk("hold_data", tx_data_o, h_data);
                chk("hold_last", last_byte, h_last);
            end
            if (valid_flag && tx_mac_ready) begin
                beats_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h, expected no beat", tx_data_o);
                end else begin
                    mb = q.pop_front();
                    chk("beat_data", tx_data_o, mb.data);
                    chk("beat_last", last_byte, mb.last);
                end
            end
            hold   = valid_flag && !tx_mac_ready;
            h_data = tx_data_o;
            h_last = last_byte;
        end
    end

    // Drives a frame (frm_len garbage after the first byte) and queues expected beats
    task automatic load_frame(input int len, input logic [7:0] base);
        int total;
        beat_t b;
        total = (len < 64) ? 64 : len;
        beats_seen = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            tx_data_valid = 1'b1;
            tx_data = base + 8'(i);
            frm_len = (i == 0) ? 16'(len) : 16'hFFFF;
            b.data = base + 8'(i);
            b.last = (i == total - 1);
            q.push_back(b);
        end
        for (int i = len; i < total; i++) begin
            b.data = 8'h00;
            b.last = (i == total - 1);
            q.push_back(b);
        end
        @(negedge clk);
        tx_data_valid = 1'b0;
        frm_len = '0;
        chk("first_beat_latency", valid_flag, 1);
        chk("in_ready_low_send", in_ready, 0);
    endtask

    task automatic run_frame(input int len, input logic [7:0] base, input int exp_beats);
        int n;
        load_frame(len, base);
        n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_drained", q.size(), 0);
        @(negedge clk);
        chk("idle_valid_low", valid_flag, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("beat_count", beats_seen, exp_beats);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{len: 64,  base: 8'h00, rdy: 0, exp_beats: 64};
        vecs[1] = '{len: 10,  base: 8'hA0, rdy: 0, exp_beats: 64};
        vecs[2] = '{len: 70,  base: 8'h10, rdy: 3, exp_beats: 70};
        vecs[3] = '{len: 1,   base: 8'h55, rdy: 0, exp_beats: 64};
        vecs[4] = '{len: 63,  base: 8'h20, rdy: 2, exp_beats: 64};
        vecs[5] = '{len: 256, base: 8'h00, rdy: 2, exp_beats: 256};

        #1;
        chk("rst_valid", valid_flag, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_last", last_byte, 0);
        chk("rst_err", frm_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int k = 0; k < 6; k++) begin
            rdy_mode = vecs[k].rdy;
            run_frame(vecs[k].len, vecs[k].base, vecs[k].exp_beats);
            rdy_mode = 0;
            @(negedge clk);
        end

        // Rejected lengths: 0 and above DEPTH
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tx_data_valid = 1'b1;
            tx_data = 8'hEE;
            frm_len = (k == 0) ? 16'd0 : 16'd300;
            @(negedge clk);
            tx_data_valid = 1'b0;
            chk("err_pulse", frm_err, 1);
            chk("err_no_valid", valid_flag, 0);
            chk("err_in_ready", in_ready, 1);
            @(negedge clk);
            chk("err_one_cycle", frm_err, 0);
            chk("err_still_idle", valid_flag, 0);
        end

        // Mid-frame reset after 20 beats
        load_frame(64, 8'h40);
        for (int n = 0; n < 500 && beats_seen < 20; n++) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        q.delete();
        chk("mid_rst_valid", valid_flag, 0);
        chk("mid_rst_data", tx_data_o, 0);
        chk("mid_rst_last", last_byte, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_hold_valid", valid_flag, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_no_beat", valid_flag, 0);
        run_frame(64, 8'hC0, 64);

        // 16-bit lane, MIN_FRM=4, two data words then two pad beats
        @(negedge clk);
        v_w = 1'b1;
        d_w = 16'h1234;
        len_w = 8'd2;
        @(negedge clk);
        d_w = 16'h5678;
        len_w = 8'd9;
        @(negedge clk);
        v_w = 1'b0;
        chk("w_b0_valid", vf_w, 1);
        chk("w_b0_data", do_w, 16'h1234);
        chk("w_b0_last", lb_w, 0);
        chk("w_in_ready_low", ir_w, 0);
        @(negedge clk);
        chk("w_b1_data", do_w, 16'h5678);
        chk("w_b1_last", lb_w, 0);
        @(negedge clk);
        chk("w_b2_data", do_w, 16'hA5A5);
        chk("w_b2_last", lb_w, 0);
        @(negedge clk);
        chk("w_b3_data", do_w, 16'hA5A5);
        chk("w_b3_last", lb_w, 1);
        @(negedge clk);
        chk("w_done_valid", vf_w, 0);
        chk("w_done_in_ready", ir_w, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: byte-lane width of tx_data and tx_data_o.
REQ-002 SHALL have parameter DEPTH, default 256: frame buffer entries, a power of two.
REQ-003 SHALL have parameter LEN_W, default 16: width of frm_len and internal counters.
REQ-004 SHALL have parameter MIN_FRM, default 64: minimum frame length on the output, in bytes.
REQ-005 SHALL have parameter PAD_BYTE, default 8'h00: value used for padding beats.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port tx_data, input, DATA_W bits: payload byte from the upstream source.
REQ-009 SHALL have port tx_data_valid, input, 1 bit: tx_data is valid this cycle.
REQ-010 SHALL have port frm_len, input, LEN_W bits: payload length, sampled on the first accepted byte of a frame.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts tx_data this cycle.
REQ-012 SHALL have port tx_data_o, output, DATA_W bits: byte to the MAC.
REQ-013 SHALL have port valid_flag, output, 1 bit: tx_data_o is valid.
REQ-014 SHALL have port tx_mac_ready, input, 1 bit: the MAC accepts tx_data_o this cycle.
REQ-015 SHALL have port last_byte, output, 1 bit: high with the final beat of a frame.
REQ-016 SHALL have port frm_err, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-017 SHALL implement a state machine with states IDLE, LOAD, SEND and PAD.
REQ-018 SHALL accept an input byte on a cycle where tx_data_valid && in_ready, writing it to buffer entry wr_cnt.
REQ-019 SHALL drive in_ready=1 in IDLE and LOAD only, and 0 in SEND and PAD.
REQ-020 IDLE: on the first accepted byte SHALL latch frm_len into len_q, store the byte at index 0, set wr_cnt=1, and go to LOAD, or go straight to SEND if frm_len==1.
REQ-021 IDLE: if frm_len==0 or frm_len>DEPTH on the first valid byte, SHALL drop the byte, pulse frm_err for 1 cycle, and stay in IDLE.
REQ-022 LOAD: SHALL increment wr_cnt per accepted byte; the accept that makes wr_cnt==len_q SHALL move the FSM to SEND on the next cycle; frm_len changes during LOAD SHALL be ignored.
REQ-023 SEND: SHALL hold valid_flag=1 with tx_data_o=buffer[rd_cnt]; a beat transfers when valid_flag && tx_mac_ready, and rd_cnt then increments.
REQ-024 While valid_flag=1 and tx_mac_ready=0, tx_data_o, valid_flag and last_byte SHALL stay stable.
REQ-025 SEND: after the transfer of beat len_q-1, SHALL go to IDLE if len_q>=MIN_FRM, otherwise to PAD.
REQ-026 PAD: SHALL output PAD_BYTE with valid_flag=1 under the same handshake until MIN_FRM total beats have transferred, then go to IDLE.
REQ-027 last_byte SHALL be 1 exactly on the final beat: beat len_q-1 if len_q>=MIN_FRM, else beat MIN_FRM-1. It SHALL be 0 on every other beat.
REQ-028 The first output beat SHALL be valid in the cycle after the last input byte is accepted (1-cycle latency). Back-to-back frames SHALL have exactly 1 IDLE cycle between them.
REQ-029 Counters SHALL be LEN_W bits wide and never wrap; the buffer index SHALL use the low log2(DEPTH) bits.

Reset
REQ-030 rst=1 SHALL asynchronously force state=IDLE, wr_cnt=0, rd_cnt=0, len_q=0, valid_flag=0, last_byte=0, frm_err=0, tx_data_o=0, in_ready=1 (in_ready once rst deasserts).
REQ-031 Buffer contents SHALL NOT be reset; rst asserted mid-frame SHALL abandon the frame, with no partial beats after release.

Verification
REQ-032 Load 64 bytes 0x00..0x3F with frm_len=64 and tx_mac_ready=1 -> 64 beats in order, last_byte only on 0x3F, no pad beats.
REQ-033 frm_len=10, bytes 0xA0..0xA9 -> 10 data beats, then 54 beats of 0x00, last_byte on beat 63 only.
REQ-034 frm_len=70, toggle tx_mac_ready every 3 cycles -> tx_data_o stable while ready is low, 70 beats, correct order, single last_byte.
REQ-035 frm_len=0, then frm_len=300 with DEPTH=256 -> frm_err pulses once each, no valid_flag, in_ready stays 1.
REQ-036 Assert rst after 20 of 64 output beats, release, then send a fresh frame with frm_len=64 -> outputs zero during reset, new frame starts from index 0 intact.
REQ-037 Set DATA_W=16, MIN_FRM=4, frm_len=2 -> 2 data beats plus 2 PAD_BYTE beats, last_byte on beat 3.
